mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_core.sv | 67 ++++++
 rtl/mul_div_unit.sv | 120 ++++++++++++
 tb/tb_mul_div_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and widths for the HI/LO multiply/divide unit.
// Divider logic is present only when MUL_DIV_UNIT_DIV_EN is defined.
package muldiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITER_N = 32;
    localparam int unsigned CNT_W  = $clog2(ITER_N);

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

    function automatic logic is_signed_op(input op_e op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic c);
        return c ? (~x + DATA_W'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
// The divide step exists only when MUL_DIV_UNIT_DIV_EN is defined.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_step,
    input  logic                i_div,
    input  logic [DATA_W-1:0]   i_a_mag,
    input  logic [DATA_W-1:0]   i_b_mag,
    output logic [2*DATA_W-1:0] o_acc
);

    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_mul_acc;
    logic [2*DATA_W-1:0] w_step_acc;

    // Upper half accumulates the multiplicand; carry shifts back in from the top.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_b & {DATA_W{r_acc[0]}}};
        w_mul_acc = {w_sum, r_acc[DATA_W-1:1]};
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    logic [DATA_W:0]     w_rem_sh;
    logic                w_ge;
    logic [DATA_W-1:0]   w_diff;
    logic [2*DATA_W-1:0] w_div_acc;

    // Shifted partial remainder needs 33 bits: it can reach 2*divisor-1.
    always_comb begin
        w_rem_sh = r_acc[2*DATA_W-1:DATA_W-1];
        w_ge     = (w_rem_sh >= {1'b0, r_b});
        w_diff   = w_rem_sh[DATA_W-1:0] - r_b;
        if (w_ge) begin
            w_div_acc = {w_diff, r_acc[DATA_W-2:0], 1'b1};
        end else begin
            w_div_acc = {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
        end
    end

    assign w_step_acc = i_div ? w_div_acc : w_mul_acc;
`else
    logic w_unused_div;
    assign w_unused_div = i_div;
    assign w_step_acc   = w_mul_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
        end else if (i_load) begin
            r_acc <= {{DATA_W{1'b0}}, i_a_mag};
            r_b   <= i_b_mag;
        end else if (i_step) begin
            r_acc <= w_step_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: control FSM, operand latches and HI/LO registers.
// Define MUL_DIV_UNIT_DIV_EN to build the divider; otherwise DIV/DIVU complete with HI/LO unchanged.
module mul_div_unit
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [1:0]        op,
    input  logic              start,
    input  logic              wr_hi,
    input  logic              wr_lo,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_e              r_state, w_state_next;
    op_e                 r_op;
    logic [DATA_W-1:0]   r_a, r_b, r_hi, r_lo;
    logic [DATA_W-1:0]   w_hi_next, w_lo_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept, w_in_signed, w_signed, w_neg, w_skip;
    logic [2*DATA_W-1:0] w_acc, w_prod;

    assign w_accept    = (r_state == StIdle) && start;
    assign w_in_signed = is_signed_op(op_e'(op));
    assign w_signed    = is_signed_op(r_op);
    assign w_neg       = w_signed && (r_a[DATA_W-1] ^ r_b[DATA_W-1]);

`ifdef MUL_DIV_UNIT_DIV_EN
    assign w_skip = 1'b0;
`else
    // Without the divider a DIV/DIVU bypasses CALC and leaves HI/LO alone.
    assign w_skip = op[1];
    logic w_unused_ops;
    assign w_unused_ops = ^{r_a, r_b};
`endif

    muldiv_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_step  (r_state == StCalc),
        .i_div   (r_op[1]),
        .i_a_mag (mag_of(data_in1)),
        .i_b_mag (mag_of(data_in2)),
        .o_acc   (w_acc)
    );

    function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] x);
        return neg_if(x, w_in_signed && x[DATA_W-1]);
    endfunction

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (start) w_state_next = w_skip ? StFix : StCalc;
            StCalc: if (r_cnt == CNT_W'(ITER_N - 1)) w_state_next = StFix;
            StFix:  w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_prod    = w_neg ? (~w_acc + (2*DATA_W)'(1)) : w_acc;
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (!r_op[1]) begin
            {w_hi_next, w_lo_next} = w_prod;
        end
`ifdef MUL_DIV_UNIT_DIV_EN
        else if (r_b == '0) begin
            w_lo_next = '1;
            w_hi_next = r_a;
        end else begin
            w_lo_next = neg_if(w_acc[DATA_W-1:0], w_neg);
            w_hi_next = neg_if(w_acc[2*DATA_W-1:DATA_W], w_signed && r_a[DATA_W-1]);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_op    <= OpMult;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op  <= op_e'(op);
                r_a   <= data_in1;
                r_b   <= data_in2;
                r_cnt <= '0;
            end else if (r_state == StCalc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == StFix) begin
                r_hi <= w_hi_next;
                r_lo <= w_lo_next;
            end else if ((r_state == StIdle) && !start) begin
                if (wr_hi) r_hi <= data_in1;
                if (wr_lo) r_lo <= data_in1;
            end
        end
    end

    assign busy = (r_state != StIdle);
    assign done = (r_state == StDone);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table through a scoreboard plus corner sequences.
module tb_mul_div_unit;

`ifdef MUL_DIV_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk, rst_n, start, wr_hi, wr_lo, busy, done;
    logic [1:0]  op;
    logic [31:0] data_in1, data_in2, hi, lo;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mul_div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .op       (op),
        .start    (start),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr_regs(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        wr_hi = 1'b1; data_in1 = h;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; data_in1 = l;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mthi", {32'h0, hi}, {32'h0, h});
        chk("mtlo", {32'h0, lo}, {32'h0, l});
    endtask

    // mode 0: plain; 1: wr_hi/wr_lo with start; 2: start/writes injected while busy.
    // Cycle n is the sample taken #1 after the (n-1)th edge following the start edge.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int mode);
        exp_t        e, got;
        logic [31:0] pre_hi, pre_lo;
        int          n;
        bit          seen;
        @(negedge clk);
        pre_hi = hi; pre_lo = lo;
        op = o; data_in1 = a; data_in2 = b; start = 1'b1;
        wr_hi = (mode == 1); wr_lo = (mode == 1);
        e.hi = eh; e.lo = el; e.cyc = (o[1] && !DIV_EN) ? 8'd2 : 8'd34;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        data_in1 = ~a; data_in2 = ~b;
        n = 1; seen = 1'b0;
        while (!seen && n <= 60) begin
            if (mode == 2 && n == 10) begin
                start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; data_in1 = 32'h1234;
            end
            if (mode == 2 && n == 11) begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            if (n == 1) chk({name, "_busy"}, {63'h0, busy}, 64'h1);
            if (n == 1 || n == 17) chk({name, "_hold"}, {hi, lo}, {pre_hi, pre_lo});
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!seen) begin
            chk({name, "_timeout"}, 64'h0, 64'h1);
            void'(sb_q.pop_front());
            return;
        end
        got = sb_q.pop_front();
        chk({name, "_cycle"}, 64'(n), 64'(got.cyc));
        chk({name, "_hilo"}, {hi, lo}, {got.hi, got.lo});
        @(posedge clk); #1;
        chk({name, "_idle"}, {62'h0, busy, done}, 64'h0);
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'b00; data_in1 = '0; data_in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {busy, done, hi, lo}, 66'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release", {busy, done, hi, lo}, 66'h0);

        wr_regs(32'hAAAA_0001, 32'h5555_0002);

        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780});
        vecs.push_back('{2'b00, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        if (DIV_EN) begin
            vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
            vecs.push_back('{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
            vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
            vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555});
            vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001});
            vecs.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
            vecs.push_back('{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
            vecs.push_back('{2'b11, 32'h0000_03E8, 32'h0000_0007, 32'h0000_0006, 32'h0000_008E});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 0);
        end

        // start with simultaneous writes: writes dropped, result as normal
        wr_regs(32'h0000_0099, 32'h0000_0088);
        run_op("start_wins", 2'b01, 32'h3, 32'h4, 32'h0, 32'hC, 1);
        // writes and a second start while busy are ignored
        run_op("busy_ignore", 2'b01, 32'h3, 32'h4, 32'h0, 32'hC, 2);

        // reset mid-operation aborts with no later done
        wr_regs(32'h0000_0077, 32'h0000_0066);
        @(negedge clk);
        op = DIV_EN ? 2'b10 : 2'b00; data_in1 = 32'hFFFF_FFF9; data_in2 = 32'h2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("abort_busy_before", {63'h0, busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {busy, done, hi, lo}, 66'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'h0);
        run_op("after_abort", 2'b01, 32'h2, 32'h2, 32'h0, 32'h4, 0);

        // DIV 10/3: full result with divider, HI/LO untouched without it
        wr_regs(32'h5, 32'h5);
        if (DIV_EN) run_op("div_10_3", 2'b10, 32'hA, 32'h3, 32'h1, 32'h3, 0);
        else        run_op("div_10_3", 2'b10, 32'hA, 32'h3, 32'h5, 32'h5, 0);

        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
